cmp_scan_ctrl: RTL and testbench

- Sequencing controller that scans a block of operands from a synchronous read port and returns the minimum or maximum element plus its index.
- Compares by subtraction (candidate minus current extreme) and latches the C/N/V/Z flags into a flag register.
- Decides each update with the standard condition codes: LO, HI, LT, GT.
- Sits beside the ALU/flag datapath as its scan controller; the last-compare flags are exported for debug and chaining.

---
 rtl/cmp_scan_ctrl.sv | 172 +++++++++++++++++
 tb/tb_cmp_scan_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmp_scan_ctrl.sv
// Min/max scan controller: walks a block of operands through a synchronous read port and
// keeps the extreme element and its index, using subtract-and-flag condition codes.
module cmp_scan_ctrl #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [ADDR_W:0]   len,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [WIDTH-1:0]  rd_data,
    output logic              busy,
    output logic              done,
    output logic [WIDTH-1:0]  result,
    output logic [ADDR_W-1:0] result_idx,
    output logic [3:0]        flags
);

    typedef enum logic [2:0] {StIdle, StReq, StCap, StEval, StDone} stateT;

    localparam logic [ADDR_W:0] MaxLen = {1'b1, {ADDR_W{1'b0}}};

    stateT             stateQ, stateD;
    logic [1:0]        modeQ;
    logic [ADDR_W:0]   lenQ;
    logic [ADDR_W-1:0] idxQ;
    logic [ADDR_W-1:0] rdAddrQ;
    logic [WIDTH-1:0]  candQ;
    logic [WIDTH-1:0]  resultQ;
    logic [ADDR_W-1:0] resultIdxQ;
    logic [3:0]        flagsQ;

    logic [ADDR_W:0]   lenClamp;
    logic [ADDR_W:0]   lenM1;
    logic [ADDR_W-1:0] idxNext;
    logic              isLast;
    logic [WIDTH:0]    diff;
    logic [3:0]        cmpFlags;
    logic              takeCand;

    assign lenClamp = (len > MaxLen) ? MaxLen : len;
    assign lenM1    = lenQ - (ADDR_W + 1)'(1);
    assign idxNext  = idxQ + ADDR_W'(1);
    assign isLast   = ({1'b0, idxQ} == lenM1);

    // Extra MSB of the difference is the borrow out; C is its inverse.
    assign diff = {1'b0, rd_data} - {1'b0, resultQ};
    assign cmpFlags = {
        ~diff[WIDTH],
        diff[WIDTH-1],
        (rd_data[WIDTH-1] ^ resultQ[WIDTH-1]) & (diff[WIDTH-1] ^ rd_data[WIDTH-1]),
        (diff[WIDTH-1:0] == '0)
    };

    // Condition codes LO / HI / LT / GT decoded from the registered {C,N,V,Z}.
    always_comb begin
        takeCand = 1'b0;
        unique case (modeQ)
            2'b00: takeCand = ~flagsQ[3];
            2'b01: takeCand = flagsQ[3] & ~flagsQ[0];
            2'b10: takeCand = flagsQ[2] ^ flagsQ[1];
            2'b11: takeCand = ~(flagsQ[2] ^ flagsQ[1]) & ~flagsQ[0];
            default: takeCand = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stateQ <= StIdle;
        end else begin
            stateQ <= stateD;
        end
    end

    always_comb begin
        stateD = stateQ;
        unique case (stateQ)
            StIdle: begin
                if (start) begin
                    stateD = (lenClamp == '0) ? StDone : StReq;
                end
            end
            StReq:  stateD = StCap;
            StCap: begin
                if (idxQ == '0) begin
                    stateD = isLast ? StDone : StReq;
                end else begin
                    stateD = StEval;
                end
            end
            StEval: stateD = isLast ? StDone : StReq;
            StDone: stateD = StIdle;
            default: stateD = StIdle;
        endcase
    end

    always_comb begin
        rd_en = 1'b0;
        busy  = 1'b0;
        done  = 1'b0;
        unique case (stateQ)
            StReq: begin
                rd_en = 1'b1;
                busy  = 1'b1;
            end
            StCap, StEval: busy = 1'b1;
            StDone: done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            modeQ      <= '0;
            lenQ       <= '0;
            idxQ       <= '0;
            rdAddrQ    <= '0;
            candQ      <= '0;
            resultQ    <= '0;
            resultIdxQ <= '0;
            flagsQ     <= '0;
        end else begin
            unique case (stateQ)
                StIdle: begin
                    if (start) begin
                        modeQ  <= mode;
                        lenQ   <= lenClamp;
                        idxQ   <= '0;
                        flagsQ <= '0;
                        if (lenClamp != '0) begin
                            rdAddrQ <= '0;
                        end
                    end
                end
                StCap: begin
                    candQ <= rd_data;
                    if (idxQ == '0) begin
                        resultQ    <= rd_data;
                        resultIdxQ <= '0;
                        if (!isLast) begin
                            idxQ    <= ADDR_W'(1);
                            rdAddrQ <= ADDR_W'(1);
                        end
                    end else begin
                        flagsQ <= cmpFlags;
                    end
                end
                StEval: begin
                    // Ties leave the earlier index in place.
                    if (takeCand) begin
                        resultQ    <= candQ;
                        resultIdxQ <= idxQ;
                    end
                    if (!isLast) begin
                        idxQ    <= idxNext;
                        rdAddrQ <= idxNext;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rd_addr    = rdAddrQ;
    assign result     = resultQ;
    assign result_idx = resultIdxQ;
    assign flags      = flagsQ;

endmodule

// File: tb/tb_cmp_scan_ctrl.sv
// Self-checking bench for cmp_scan_ctrl: fixed vector table, randomized scans against an
// integer-arithmetic reference model, and hand sequences for busy-start and mid-scan reset.
module tb_cmp_scan_ctrl;

    logic       clk = 1'b0;
    logic       resetN;
    logic       start;
    logic [1:0] mode;
    logic [4:0] len;
    logic       rdEn;
    logic [3:0] rdAddr;
    logic [7:0] rdData;
    logic       busy;
    logic       done;
    logic [7:0] result;
    logic [3:0] resultIdx;
    logic [3:0] flags;

    logic [7:0] mem [16];
    int         rdLog [$];
    int         nChecks = 0;
    int         nPass   = 0;

    cmp_scan_ctrl #(.WIDTH(8), .ADDR_W(4)) dut (
        .clk        (clk),
        .reset_n    (resetN),
        .start      (start),
        .mode       (mode),
        .len        (len),
        .rd_en      (rdEn),
        .rd_addr    (rdAddr),
        .rd_data    (rdData),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .result_idx (resultIdx),
        .flags      (flags)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rdEn) rdData <= mem[rdAddr];
    end

    always @(negedge clk) begin
        if (rdEn === 1'b1) rdLog.push_back(int'(rdAddr));
    end

    typedef struct packed {
        logic [1:0]       mode;
        logic [4:0]       len;
        logic [15:0][7:0] data;
        logic [7:0]       expResult;
        logic [3:0]       expIdx;
        logic [3:0]       expFlags;
        logic [7:0]       expCycles;
    } vecT;

    vecT vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act === exp) nPass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Starts a scan and returns the cycle (1 = cycle after the start edge) in which done is
    // seen, or -1 on timeout. A nonzero pokeAt raises a bogus start during that cycle.
    task automatic runScan(input logic [1:0] m, input int l, input int pokeAt,
                           output int cyc);
        @(posedge clk); #1;
        mode  = m;
        len   = 5'(l);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc   = 1;
        while (!done && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
            start = (cyc == pokeAt);
            if (start) begin
                mode = ~m;
                len  = 5'd1;
            end
        end
        if (!done) cyc = -1;
        if (start) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
    endtask

    // Reference: integer comparisons straight from the min/max rules.
    task automatic refScan(input logic [1:0] m, input int l, output logic [7:0] r,
                           output int ri, output logic [3:0] f);
        int n;
        int du;
        int ds;
        logic [7:0] d8;
        logic better;
        n  = (l > 16) ? 16 : l;
        r  = mem[0];
        ri = 0;
        f  = 4'b0;
        for (int i = 1; i < n; i++) begin
            du = int'(mem[i]) - int'(r);
            ds = int'($signed(mem[i])) - int'($signed(r));
            d8 = 8'(du);
            f  = {du >= 0, d8[7], (ds > 127 || ds < -128), du == 0};
            case (m)
                2'b00:   better = (du < 0);
                2'b01:   better = (du > 0);
                2'b10:   better = (ds < 0);
                default: better = (ds > 0);
            endcase
            if (better) begin
                r  = mem[i];
                ri = i;
            end
        end
    endtask

    initial begin
        int cyc;
        int logStart;
        int badAddr;
        int doneSeen;
        int ri;
        int l;
        logic [1:0] m;
        logic [7:0] r;
        logic [3:0] f;

        for (int k = 0; k < 8; k++) vecs[k] = '0;
        vecs[0].mode = 2'b00; vecs[0].len = 5'd0;
        vecs[0].expCycles = 8'd1;
        vecs[1].mode = 2'b00; vecs[1].len = 5'd4;
        vecs[1].data[0] = 8'h40; vecs[1].data[1] = 8'h10;
        vecs[1].data[2] = 8'h80; vecs[1].data[3] = 8'h10;
        vecs[1].expResult = 8'h10; vecs[1].expIdx = 4'd1;
        vecs[1].expFlags = 4'b1001; vecs[1].expCycles = 8'd12;
        vecs[2].mode = 2'b01; vecs[2].len = 5'd3;
        vecs[2].data[0] = 8'h7F; vecs[2].data[1] = 8'h80; vecs[2].data[2] = 8'h01;
        vecs[2].expResult = 8'h80; vecs[2].expIdx = 4'd1;
        vecs[2].expFlags = 4'b0110; vecs[2].expCycles = 8'd9;
        vecs[3] = vecs[2];
        vecs[3].mode = 2'b11;
        vecs[3].expResult = 8'h7F; vecs[3].expIdx = 4'd0;
        vecs[3].expFlags = 4'b0100;
        vecs[4].mode = 2'b10; vecs[4].len = 5'd2;
        vecs[4].data[0] = 8'h7F; vecs[4].data[1] = 8'h80;
        vecs[4].expResult = 8'h80; vecs[4].expIdx = 4'd1;
        vecs[4].expFlags = 4'b1010; vecs[4].expCycles = 8'd6;
        vecs[5].mode = 2'b01; vecs[5].len = 5'd1;
        vecs[5].data[0] = 8'h5A;
        vecs[5].expResult = 8'h5A; vecs[5].expCycles = 8'd3;
        vecs[6].mode = 2'b00; vecs[6].len = 5'd16;
        for (int i = 0; i < 16; i++) vecs[6].data[i] = 8'(200 - i * 7);
        vecs[6].expResult = 8'h5F; vecs[6].expIdx = 4'd15;
        vecs[6].expFlags = 4'b0100; vecs[6].expCycles = 8'd48;
        vecs[7].mode = 2'b01; vecs[7].len = 5'd20;
        for (int i = 0; i < 16; i++) vecs[7].data[i] = 8'(i * 5);
        vecs[7].expResult = 8'h4B; vecs[7].expIdx = 4'd15;
        vecs[7].expFlags = 4'b1000; vecs[7].expCycles = 8'd48;

        resetN = 1'b0;
        start  = 1'b0;
        mode   = 2'b00;
        len    = 5'd0;
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy",   32'(busy),      32'd0);
        check("reset_done",   32'(done),      32'd0);
        check("reset_rd_en",  32'(rdEn),      32'd0);
        check("reset_rd_addr", 32'(rdAddr),   32'd0);
        check("reset_result", 32'(result),    32'd0);
        check("reset_idx",    32'(resultIdx), 32'd0);
        check("reset_flags",  32'(flags),     32'd0);
        resetN = 1'b1;

        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < 16; i++) mem[i] = vecs[k].data[i];
            logStart = rdLog.size();
            runScan(vecs[k].mode, int'(vecs[k].len), 0, cyc);
            check($sformatf("vec%0d_cycles", k), 32'(cyc),       32'(vecs[k].expCycles));
            check($sformatf("vec%0d_result", k), 32'(result),    32'(vecs[k].expResult));
            check($sformatf("vec%0d_idx", k),    32'(resultIdx), 32'(vecs[k].expIdx));
            check($sformatf("vec%0d_flags", k),  32'(flags),     32'(vecs[k].expFlags));
            badAddr = 0;
            for (int j = logStart; j < rdLog.size(); j++) begin
                if (rdLog[j] != j - logStart) badAddr++;
            end
            check($sformatf("vec%0d_reads", k), 32'(rdLog.size() - logStart),
                  (vecs[k].len > 16) ? 32'd16 : 32'(vecs[k].len));
            check($sformatf("vec%0d_addr_order", k), 32'(badAddr), 32'd0);
        end

        for (int t = 0; t < 30; t++) begin
            m = 2'($urandom_range(0, 3));
            l = int'($urandom_range(1, 18));
            for (int i = 0; i < 16; i++) begin
                mem[i] = (t % 3 == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom);
            end
            refScan(m, l, r, ri, f);
            runScan(m, l, 0, cyc);
            check($sformatf("rnd%0d_cycles", t), 32'(cyc), 32'(3 * ((l > 16) ? 16 : l)));
            check($sformatf("rnd%0d_result", t), 32'(result),    32'(r));
            check($sformatf("rnd%0d_idx", t),    32'(resultIdx), 32'(ri));
            check($sformatf("rnd%0d_flags", t),  32'(flags),     32'(f));
        end

        // Bogus start mid-scan must not disturb the running scan.
        for (int i = 0; i < 16; i++) mem[i] = vecs[1].data[i];
        runScan(2'b00, 4, 5, cyc);
        check("busy_start_cycles", 32'(cyc),       32'd12);
        check("busy_start_result", 32'(result),    32'h10);
        check("busy_start_idx",    32'(resultIdx), 32'd1);

        // Start raised in the DONE cycle must be ignored.
        runScan(2'b00, 4, 12, cyc);
        check("done_start_cycles", 32'(cyc), 32'd12);
        @(posedge clk); #1;
        check("done_start_busy", 32'(busy), 32'd0);
        check("done_start_rd_en", 32'(rdEn), 32'd0);

        // Asynchronous reset in the middle of a scan.
        for (int i = 0; i < 16; i++) mem[i] = 8'(8'h30 + i);
        @(posedge clk); #1;
        mode  = 2'b01;
        len   = 5'd8;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (7) begin
            @(posedge clk); #1;
        end
        #2;
        resetN = 1'b0;
        #1;
        check("midrst_busy",    32'(busy),      32'd0);
        check("midrst_done",    32'(done),      32'd0);
        check("midrst_rd_en",   32'(rdEn),      32'd0);
        check("midrst_rd_addr", 32'(rdAddr),    32'd0);
        check("midrst_result",  32'(result),    32'd0);
        check("midrst_idx",     32'(resultIdx), 32'd0);
        check("midrst_flags",   32'(flags),     32'd0);
        doneSeen = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (done) doneSeen++;
        end
        resetN = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            if (done) doneSeen++;
        end
        check("midrst_no_done", 32'(doneSeen), 32'd0);
        refScan(2'b10, 8, r, ri, f);
        runScan(2'b10, 8, 0, cyc);
        check("post_rst_cycles", 32'(cyc),       32'd24);
        check("post_rst_result", 32'(result),    32'(r));
        check("post_rst_idx",    32'(resultIdx), 32'(ri));
        check("post_rst_flags",  32'(flags),     32'(f));

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
